// File: rtl/audio_sample_buffer.sv
// Audio sample buffer. It assembles little-endian 16-bit mono samples from SD block bytes,
// stores them in a FIFO, asks for whole 512-byte blocks when there is room, and plays them out at a fixed rate.
`timescale 1ns/1ps
module audio_sample_buffer #(
    parameter int FIFO_ADDR_BITS = 10,
    parameter int SAMPLE_DIV     = 1134
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [7:0]                byte_in,
    input  logic [8:0]                byte_idx,
    input  logic                      byte_valid,
    output logic                      block_request,
    output logic [15:0]               sample_out,
    output logic                      sample_strobe,
    output logic [FIFO_ADDR_BITS:0]   fifo_level,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int DEPTH         = 1 << FIFO_ADDR_BITS;
    localparam int BLOCK_SAMPLES = 256;
    localparam int DIV_BITS      = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    localparam logic [DIV_BITS-1:0]     DIV_LAST   = DIV_BITS'(SAMPLE_DIV - 1);
    localparam logic [FIFO_ADDR_BITS:0] LEVEL_FULL = (FIFO_ADDR_BITS + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQUEST,
        ST_RECEIVE
    } state_t;

    state_t                    state_q, state_d;
    logic [DIV_BITS-1:0]       div_q, div_d;
    logic [FIFO_ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_ADDR_BITS:0]   level_q, level_d;
    logic [7:0]                low_byte_q, low_byte_d;
    logic                      strobe_q, strobe_d;
    logic                      overflow_q, overflow_d;
    logic                      underflow_q, underflow_d;
    logic [15:0]               sample_out_q;

    logic [15:0] mem [DEPTH];

    logic        push;
    logic        push_ok;
    logic        tick;
    logic        pop_ok;
    logic [15:0] push_data;
    int          free_space;

    // Odd byte completes a sample; it always pairs with whatever low byte was latched last.
    always_comb begin
        push      = byte_valid & byte_idx[0];
        push_ok   = push & (level_q != LEVEL_FULL);
        push_data = {byte_in, low_byte_q};
        tick      = enable & (div_q == DIV_LAST);
        pop_ok    = tick & (level_q != '0);
        free_space = DEPTH - int'(level_q);
    end

    always_comb begin
        low_byte_d  = low_byte_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        div_d       = div_q;
        strobe_d    = tick;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (byte_valid && !byte_idx[0]) begin
            low_byte_d = byte_in;
        end
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (push && !push_ok) begin
            overflow_d = 1'b1;
        end
        // An empty FIFO underflows even if a push lands in the same cycle.
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (tick && !pop_ok) begin
            underflow_d = 1'b1;
        end

        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        if (enable) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        end
    end

    // Once a request is out, the reader is waiting for a block start; keep asking until it arrives.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable && (free_space >= BLOCK_SAMPLES)) begin
                    state_d = ST_REQUEST;
                end
            end
            ST_REQUEST: begin
                if (byte_valid && (byte_idx == 9'd0)) begin
                    state_d = ST_RECEIVE;
                end
            end
            ST_RECEIVE: begin
                if (byte_valid && (byte_idx == 9'd511)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            low_byte_q  <= '0;
            strobe_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            low_byte_q  <= low_byte_d;
            strobe_q    <= strobe_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Sample storage: no reset, so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    // The output register doubles as the RAM read register; it only loads on a tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sample_out_q <= '0;
        end else if (tick) begin
            sample_out_q <= pop_ok ? mem[rd_ptr_q] : 16'h0000;
        end
    end

    assign block_request = (state_q == ST_REQUEST);
    assign sample_out    = sample_out_q;
    assign sample_strobe = strobe_q;
    assign fifo_level    = level_q;
    assign overflow      = overflow_q;
    assign underflow     = underflow_q;

endmodule

// File: tb/tb_audio_sample_buffer.sv
// Directed bench for audio_sample_buffer with a 256-sample FIFO and a 4-cycle sample period.
`timescale 1ns/1ps
module tb_audio_sample_buffer;

    localparam int FAB = 8;
    localparam int DIV = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           enable = 1'b0;
    logic [7:0]     byte_in = 8'h00;
    logic [8:0]     byte_idx = 9'd0;
    logic           byte_valid = 1'b0;
    logic           block_request;
    logic [15:0]    sample_out;
    logic           sample_strobe;
    logic [FAB:0]   fifo_level;
    logic           overflow;
    logic           underflow;

    int n_checks = 0;
    int n_pass   = 0;
    int gap      = 0;

    audio_sample_buffer #(
        .FIFO_ADDR_BITS(FAB),
        .SAMPLE_DIV    (DIV)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .byte_in      (byte_in),
        .byte_idx     (byte_idx),
        .byte_valid   (byte_valid),
        .block_request(block_request),
        .sample_out   (sample_out),
        .sample_strobe(sample_strobe),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [8:0] idx, input logic [7:0] val);
        byte_idx   = idx;
        byte_in    = val;
        byte_valid = 1'b1;
        step(1);
        byte_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
    endtask

    // Steps until sample_strobe is seen; gap returns the number of clocks taken.
    task automatic wait_strobe();
        gap = 0;
        do begin
            step(1);
            gap++;
        end while (!sample_strobe && gap < 20);
        if (!sample_strobe) check("strobe_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;

        // Reset state
        step(2);
        check("rst_block_request", block_request, 0);
        check("rst_sample_out",    sample_out,    0);
        check("rst_sample_strobe", sample_strobe, 0);
        check("rst_fifo_level",    fifo_level,    0);
        check("rst_overflow",      overflow,      0);
        check("rst_underflow",     underflow,     0);
        rst_n = 1'b1;

        // Empty FIFO playback: silent samples, underflow, fixed strobe period
        enable = 1'b1;
        step(1);
        check("req_on_enable", block_request, 1);
        wait_strobe();
        check("uf_sample_out", sample_out, 0);
        check("uf_flag",       underflow,  1);
        wait_strobe();
        check("strobe_period_empty", gap, DIV);
        check("uf_sample_out2",      sample_out, 0);
        enable = 1'b0;

        // Full block transfer with playback paused
        do_reset();
        check("uf_cleared_by_reset", underflow, 0);
        check("req_idle_after_rst",  block_request, 0);
        enable = 1'b1;
        step(1);
        enable = 1'b0;
        step(1);
        check("req_held_in_request", block_request, 1);
        for (int i = 0; i < 512; i++) begin
            b = (i % 2 == 0) ? 8'((i / 2) & 255) : 8'h80;
            send_byte(9'(i), b);
            if (i == 0) check("req_low_in_receive", block_request, 0);
        end
        check("block_level",       fifo_level,    256);
        check("block_req_done",    block_request, 0);
        check("block_no_overflow", overflow,      0);

        // One more sample into a full FIFO is dropped
        send_byte(9'd1, 8'h55);
        check("ovf_flag",  overflow,   1);
        check("ovf_level", fifo_level, 256);

        // Playback of the block head
        enable = 1'b1;
        wait_strobe();
        check("head_after_ovf",  sample_out, 16'h8000);
        check("level_after_pop", fifo_level, 255);
        wait_strobe();
        check("strobe_period", gap,        DIV);
        check("second_sample", sample_out, 16'h8001);
        check("level_pop2",    fifo_level, 254);

        // Push in the tick cycle: level unchanged
        step(DIV - 1);
        send_byte(9'd3, 8'h77);
        check("tick_push_strobe", sample_strobe, 1);
        check("push_pop_level",   fifo_level,    254);
        check("third_sample",     sample_out,    16'h8002);
        enable = 1'b0;

        // Single sample assembly and playback
        do_reset();
        send_byte(9'd0, 8'h34);
        send_byte(9'd1, 8'h12);
        check("push_visible", fifo_level, 1);
        enable = 1'b1;
        wait_strobe();
        check("assembled_sample", sample_out, 16'h1234);
        check("level_to_zero",    fifo_level, 0);
        check("no_uf_with_data",  underflow,  0);

        // Push into an empty FIFO on the tick cycle does not bypass
        step(DIV - 1);
        send_byte(9'd1, 8'h56);
        check("nobypass_strobe", sample_strobe, 1);
        check("nobypass_out",    sample_out,    0);
        check("nobypass_uf",     underflow,     1);
        check("nobypass_level",  fifo_level,    1);
        enable = 1'b0;

        // Reset in the middle of a block
        do_reset();
        enable = 1'b1;
        step(1);
        check("req_before_block", block_request, 1);
        enable = 1'b0;
        for (int i = 0; i < 100; i++) begin
            send_byte(9'(i), 8'(i));
        end
        check("mid_block_req",   block_request, 0);
        check("mid_block_level", fifo_level,    50);
        rst_n = 1'b0;
        send_byte(9'd100, 8'h64);
        rst_n = 1'b1;
        check("midrst_block_request", block_request, 0);
        check("midrst_fifo_level",    fifo_level,    0);
        check("midrst_sample_out",    sample_out,    0);
        check("midrst_strobe",        sample_strobe, 0);
        check("midrst_overflow",      overflow,      0);
        check("midrst_underflow",     underflow,     0);
        enable = 1'b1;
        step(1);
        check("req_after_reset", block_request, 1);
        enable = 1'b0;
        send_byte(9'd101, 8'hAB);
        check("stray_odd_level", fifo_level,    1);
        check("stray_odd_state", block_request, 1);
        enable = 1'b1;
        wait_strobe();
        check("low_byte_cleared", sample_out, 16'hAB00);
        enable = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/audio_sample_buffer.md
AUDIO_SAMPLE_BUFFER -- requirements
Module: audio_sample_buffer

Interface
REQ-001 Parameter FIFO_ADDR_BITS, default 10, SHALL set FIFO depth to 2^FIFO_ADDR_BITS 16-bit samples.
REQ-002 Parameter SAMPLE_DIV, default 1134, SHALL set clock cycles per output sample (50 MHz / 1134 ≈ 44.1 kHz).
REQ-003 clk  input  1  system clock; all logic SHALL be on its rising edge.
REQ-004 rst_n  input  1  reset; SHALL be synchronous and active-low.
REQ-005 enable  input  1  playback enable: gates block requests and sample clocking.
REQ-006 byte_in  input  8  data byte from the SD block reader.
REQ-007 byte_idx  input  9  byte index within the current 512-byte block.
REQ-008 byte_valid  input  1  one-cycle pulse: byte_in/byte_idx valid.
REQ-009 block_request  output  1  level; high while the block wants the next 512-byte block.
REQ-010 sample_out  output  16  current signed PCM sample.
REQ-011 sample_strobe  output  1  one-cycle pulse when sample_out updates.
REQ-012 fifo_level  output  FIFO_ADDR_BITS+1  samples currently stored.
REQ-013 overflow  output  1  sticky: a sample was dropped on full FIFO.
REQ-014 underflow  output  1  sticky: a sample tick found the FIFO empty.

Function
REQ-015 Byte assembly SHALL treat data as 16-bit little-endian mono: even byte_idx latches the low byte; odd byte_idx pushes {byte_in, latched_low} into the FIFO.
REQ-016 An odd-index byte SHALL push using the last latched low byte, even if no even byte preceded it.
REQ-017 A push SHALL be visible in fifo_level one cycle after the byte_valid cycle.
REQ-018 A push while fifo_level == 2^FIFO_ADDR_BITS SHALL be dropped and SHALL set overflow.
REQ-019 The request FSM SHALL have states IDLE, REQUEST and RECEIVE.
REQ-020 IDLE -> REQUEST SHALL occur when enable=1 and free space (depth - fifo_level) >= 256.
REQ-021 block_request SHALL be 1 exactly while in REQUEST.
REQ-022 REQUEST -> RECEIVE SHALL occur on byte_valid with byte_idx == 0.
REQ-023 RECEIVE -> IDLE SHALL occur on byte_valid with byte_idx == 511.
REQ-024 byte_valid in IDLE or REQUEST with byte_idx != 0 SHALL still be assembled and pushed per REQ-015, with no state change.
REQ-025 enable falling in RECEIVE SHALL let the current block complete; enable=0 SHALL block IDLE -> REQUEST.
REQ-026 The divider counter SHALL count 0..SAMPLE_DIV-1 and wrap while enable=1, and SHALL hold its value while enable=0.
REQ-027 The cycle after the counter equals SAMPLE_DIV-1 (sample tick), sample_strobe SHALL be 1 and sample_out SHALL take the popped FIFO head.
REQ-028 On a tick with the FIFO empty, sample_out SHALL become 0, underflow SHALL set, and sample_strobe SHALL still pulse.
REQ-029 A simultaneous push and pop SHALL both occur and leave fifo_level unchanged.
REQ-030 A push does not bypass to an empty FIFO's pop in the same cycle: that pop SHALL be an underflow.
REQ-031 Read and write pointers SHALL wrap modulo 2^FIFO_ADDR_BITS.

Reset
REQ-032 With rst_n=0 at a clock edge, FSM SHALL go to IDLE and the divider, pointers and latched low byte SHALL clear.
REQ-033 On that reset, block_request, sample_out, sample_strobe, fifo_level, overflow and underflow SHALL all clear to 0.
REQ-034 Reset mid-RECEIVE SHALL abandon the block; subsequent bytes SHALL be handled per REQ-024.
REQ-035 FIFO RAM contents need not clear on reset.

Verification
REQ-036 Reset then enable=1 -> block_request=1 next cycle; 512 bytes 0x00,0x80,0x01,0x80.. (idx 0..511) -> fifo_level=256, block_request=0 during RECEIVE.
REQ-037 Before any samples, SAMPLE_DIV=4, enable=1 -> sample_strobe every 4 cycles, sample_out=0x0000, underflow=1.
REQ-038 Load bytes 0x34,0x12 -> next tick: sample_out=0x1234, fifo_level decrements 1 -> 0.
REQ-039 FIFO_ADDR_BITS=8, fill 256 samples, push one more -> overflow=1, fifo_level stays 256, head sample unchanged.
REQ-040 Push on the same cycle as a tick with fifo_level=5 -> fifo_level remains 5.
REQ-041 Reset asserted at byte_idx=100 of a block -> all outputs 0 next cycle; after release with enable=1 -> block_request=1 again.
